skolem_ic_sweep_checker: RTL and testbench
==========================================

# skolem_ic_sweep_checker

Exhaustive sequential checker placed directly upstream of a combinational Skolem-function block. It drives every 2·W-bit input vector into the Skolem block and samples its single-bit output. It computes the golden invertibility condition for bvugt/bvashr by brute force over all shift amounts, then reports the mismatch count and the first failing vector. It is the stage that generates and consumes the vectors for one synthesized Skolem netlist, in simulation or on an FPGA harness.

## Interface
- W, 4, operand width; the Skolem block has 2·W inputs.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; ignored unless idle.
- sk_in  output  2W  vector to the Skolem block; sk_in[W-1:0] = s, sk_in[2W-1:W] = t.
- sk_out  input  1  Skolem block output; combinational function of sk_in.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the sweep completes.
- err_count  output  2W+1  number of vectors where sk_out ≠ golden.
- fail_valid  output  1  set when the first mismatch is seen.
- first_fail  output  2W  sk_in value of the first mismatch.

## Operation
- Golden predicate: golden(s,t) = ∃ x ∈ [0, 2^W) such that (s >>arith x) >u t. Shift amounts ≥ W saturate to the sign fill.
- FSM states:
  - IDLE: start=1 clears err_count, fail_valid, first_fail and x; sets vec=0; goes to EVAL.
  - EVAL: one x per cycle, x = 0 .. 2^W-1. acc |= ((s >>a x) >u t). After x = 2^W-1 the FSM goes to CMP.
  - CMP: compare the sampled sk_out against acc.
    - On mismatch, err_count increments.
    - If fail_valid=0 on that mismatch, first_fail ← sk_in and fail_valid ← 1.
    - Clear acc and x.
    - If vec = 2^(2W)-1, go to DONE. Otherwise vec++ and go to EVAL.
  - DONE: done=1 for one cycle, then return to IDLE.
- sk_in = vec. It is held stable from the first EVAL cycle through CMP for each vector, and holds its last value in IDLE.
- err_count cannot overflow: width 2W+1 covers 2^(2W).
- start while busy is ignored. Results stay readable in IDLE until the next start.
- Reset mid-sweep: all registers clear immediately and the FSM enters IDLE. No done pulse is issued.

## Timing
- Reset values: sk_in=0, busy=0, done=0, err_count=0, fail_valid=0, first_fail=0.
- Start accepted at edge 0. EVAL occupies edges 1..2^W. CMP is at edge 2^W+1.
- Per-vector period is 2^W+1 cycles: 17 for W=4.
- done is high in the cycle after the last CMP. For W=4 that is edge 256·17+1 = 4353 after start.
- sk_out is sampled only in CMP, at least 2^W cycles after sk_in changes. The Skolem block needs no pipeline alignment.
- busy falls together with the done pulse.
- fail_valid and err_count update on the CMP edge of the failing vector.

## Test plan
- Correct Skolem model (sk_out = golden): full sweep -> err_count=0, fail_valid=0, done at cycle 4353.
- sk_out tied 0 -> err_count=148, first_fail=8'h01 (s=1, t=0). Derivation: s=0..7 contribute s each (28); s=8..15 contribute 15 each (120).
- sk_out tied 1 -> err_count=108, first_fail=8'h00.
- Spot golden checks, by forcing a wrong sk_out only at each vector and expecting first_fail to equal that vector:
  - s=4'h8, t=4'hE -> golden 1.
  - s=4'h8, t=4'hF -> golden 0.
  - s=4'h7, t=4'h6 -> golden 1.
- Assert rst at cycle 2000, release, then start -> all outputs at reset values immediately. The fresh sweep completes 4353 cycles after the new start with correct counts.
- Pulse start at cycles 10 and 3000 of a sweep -> both ignored. Exactly one done pulse at 4353, and err_count is unchanged from a clean run.

Source files
------------

// File: rtl/skolem_ic_sweep_checker.sv
// -----------------------------------------------------------------------------
// skolem_ic_sweep_checker
//
// Exhaustive sequential checker for a combinational Skolem-function block
// implementing the bvugt/bvashr invertibility condition. Every 2W-bit vector
// {t, s} is driven on sk_in in turn. For each vector the golden predicate
//
//    golden(s,t) = exists x in [0, 2^W) : (s >>> x) >u t
//
// is accumulated by brute force, one shift amount per cycle. The Skolem output
// is then compared against it, and mismatches are counted. The first failing
// vector is captured.
//
// Ports
//    clk         rising-edge clock
//    rst         asynchronous, active-high reset
//    start       one-cycle sweep request (ignored unless idle)
//    sk_in       vector to the Skolem block: [W-1:0] = s, [2W-1:W] = t
//    sk_out      Skolem block output (combinational in sk_in)
//    busy        high while a sweep is in progress (EVAL/CMP)
//    done        one-cycle pulse when the sweep completes
//    err_count   number of vectors with sk_out != golden
//    fail_valid  a mismatch has been captured in first_fail
//    first_fail  sk_in of the first mismatch
//    dbg_state   current FSM state (0 IDLE, 1 EVAL, 2 CMP, 3 DONE)
//
// Handshake: start is a single-cycle request sampled only in IDLE; there is no
// backpressure. done is a single-cycle completion strobe, and results on
// err_count/fail_valid/first_fail stay stable from done until the next start.
// -----------------------------------------------------------------------------
module skolem_ic_sweep_checker #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [2*W-1:0]   sk_in,
   input  logic             sk_out,
   output logic             busy,
   output logic             done,
   output logic [2*W:0]     err_count,
   output logic             fail_valid,
   output logic [2*W-1:0]   first_fail,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_CMP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [W-1:0]   X_ONE   = {{(W-1){1'b0}}, 1'b1};
   localparam logic [2*W-1:0] VEC_ONE = {{(2*W-1){1'b0}}, 1'b1};
   localparam logic [2*W:0]   ERR_ONE = {{(2*W){1'b0}}, 1'b1};

   state_t          r_state;
   state_t          w_next_state;
   logic [2*W-1:0]  r_vec;
   logic [W-1:0]    r_x;
   logic            r_acc;
   logic [2*W:0]    r_err;
   logic            r_fail_valid;
   logic [2*W-1:0]  r_first_fail;

   logic [W-1:0]    w_s;
   logic [W-1:0]    w_t;
   logic [W-1:0]    w_shifted;
   logic            w_hit;
   logic            w_x_last;
   logic            w_vec_last;
   logic            w_mismatch;

   assign w_s = r_vec[W-1:0];
   assign w_t = r_vec[2*W-1:W];

   // Arithmetic shift by a W-bit amount: shift amounts >= W naturally
   // saturate to the sign fill, matching bvashr semantics.
   assign w_shifted  = $signed(w_s) >>> r_x;
   assign w_hit      = (w_shifted > w_t);
   assign w_x_last   = (r_x == {W{1'b1}});
   assign w_vec_last = (r_vec == {(2*W){1'b1}});
   // In CMP, r_acc holds the complete golden value for the current vector.
   assign w_mismatch = (sk_out != r_acc);

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next_state = ST_EVAL;
         ST_EVAL: if (w_x_last) w_next_state = ST_CMP;
         ST_CMP:  w_next_state = w_vec_last ? ST_DONE : ST_EVAL;
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec        <= '0;
         r_x          <= '0;
         r_acc        <= 1'b0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_first_fail <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_vec        <= '0;
                  r_x          <= '0;
                  r_acc        <= 1'b0;
                  r_err        <= '0;
                  r_fail_valid <= 1'b0;
                  r_first_fail <= '0;
               end
            end
            ST_EVAL: begin
               r_acc <= r_acc | w_hit;
               r_x   <= r_x + X_ONE;
            end
            ST_CMP: begin
               if (w_mismatch) begin
                  r_err <= r_err + ERR_ONE;
                  if (!r_fail_valid) begin
                     r_fail_valid <= 1'b1;
                     r_first_fail <= r_vec;
                  end
               end
               r_acc <= 1'b0;
               r_x   <= '0;
               // The last vector stays on sk_in after the sweep ends.
               if (!w_vec_last) r_vec <= r_vec + VEC_ONE;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign sk_in      = r_vec;
   assign busy       = (r_state == ST_EVAL) || (r_state == ST_CMP);
   assign done       = (r_state == ST_DONE);
   assign err_count  = r_err;
   assign fail_valid = r_fail_valid;
   assign first_fail = r_first_fail;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_skolem_ic_sweep_checker.sv
// -----------------------------------------------------------------------------
// Testbench for skolem_ic_sweep_checker (W = 4).
// A behavioural Skolem model drives sk_out: correct, tied low, tied high, or
// correct except at one chosen vector. Expected sweep results are pushed to a
// queue before each sweep and popped when done is observed.
// -----------------------------------------------------------------------------
module tb_skolem_ic_sweep_checker;

   localparam int W         = 4;
   localparam int DONE_EDGE = 4353;
   localparam int BUDGET    = 6000;

   localparam int MODE_GOLD = 0;
   localparam int MODE_LOW  = 1;
   localparam int MODE_HIGH = 2;
   localparam int MODE_SPOT = 3;

   logic         clk;
   logic         rst;
   logic         start;
   logic [7:0]   sk_in;
   logic         sk_out;
   logic         busy;
   logic         done;
   logic [8:0]   err_count;
   logic         fail_valid;
   logic [7:0]   first_fail;
   logic [1:0]   dbg_state;

   int           mode;
   logic [7:0]   spot_vec;
   logic         spot_wrong;

   // {done_edge[12:0], err_count[8:0], fail_valid, first_fail[7:0]}
   logic [31:0]  exp_q[$];
   int           n_checks;
   int           n_errors;

   skolem_ic_sweep_checker #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sk_in      (sk_in),
      .sk_out     (sk_out),
      .busy       (busy),
      .done       (done),
      .err_count  (err_count),
      .fail_valid (fail_valid),
      .first_fail (first_fail),
      .dbg_state  (dbg_state)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   // Shift written on a sign-extended byte, with explicit saturation for x >= 4.
   function automatic logic golden_f(input logic [3:0] s, input logic [3:0] t);
      logic [7:0] ext;
      logic [7:0] ext_sh;
      logic [3:0] sh;
      logic       r;
      r   = 1'b0;
      ext = {{4{s[3]}}, s};
      for (int x = 0; x < 16; x++) begin
         if (x >= 4) begin
            sh = {4{s[3]}};
         end else begin
            ext_sh = ext >> x;
            sh     = ext_sh[3:0];
         end
         if (sh > t) r = 1'b1;
      end
      return r;
   endfunction

   always_comb begin
      sk_out = 1'b0;
      case (mode)
         MODE_GOLD: sk_out = golden_f(sk_in[3:0], sk_in[7:4]);
         MODE_LOW:  sk_out = 1'b0;
         MODE_HIGH: sk_out = 1'b1;
         default:   sk_out = (sk_in == spot_vec) ? spot_wrong
                                                  : golden_f(sk_in[3:0], sk_in[7:4]);
      endcase
   end

   // ---------------------------------------------------------------- driver
   task automatic push_exp(input int edge_n, input int err, input logic fv,
                           input logic [7:0] ff);
      logic [12:0] e13;
      logic [8:0]  err9;
      e13  = 13'(edge_n);
      err9 = 9'(err);
      exp_q.push_back({1'b0, e13, err9, fv, ff});
   endtask

   // Runs one full sweep. done_edge is the index of the first clock edge that
   // samples done high, counting the start-accepting edge as edge 0.
   task automatic drive_sweep(input bit inject_starts);
      logic [31:0] exp;
      int          cycles;
      bit          seen;
      int          extra_done;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cycles = 0;
      seen   = 0;
      while (!seen && cycles < BUDGET) begin
         @(posedge clk);
         cycles++;
         #1;
         start = inject_starts && (cycles == 10 || cycles == 3000);
         if (done) seen = 1;
      end
      start = 1'b0;

      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL sweep_timeout: done not seen within %0d cycles", BUDGET);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL scoreboard_empty: no expectation queued");
      end else begin
         exp = exp_q.pop_front();
         n_checks++;
         if ((cycles + 1) !== int'(exp[30:18])) begin
            n_errors++;
            $display("FAIL done_edge: got %0d expected %0d", cycles + 1, exp[30:18]);
         end
         n_checks++;
         if (err_count !== exp[17:9]) begin
            n_errors++;
            $display("FAIL err_count: got %0d expected %0d", err_count, exp[17:9]);
         end
         n_checks++;
         if (fail_valid !== exp[8]) begin
            n_errors++;
            $display("FAIL fail_valid: got %b expected %b", fail_valid, exp[8]);
         end
         n_checks++;
         if (first_fail !== exp[7:0]) begin
            n_errors++;
            $display("FAIL first_fail: got %h expected %h", first_fail, exp[7:0]);
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL busy_at_done: got %b expected 0", busy);
      end
      // done must be a single pulse and the FSM must settle in IDLE.
      extra_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) extra_done++;
      end
      n_checks++;
      if (extra_done !== 0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL post_done: extra_done=%0d busy=%b state=%0d expected 0/0/0",
                  extra_done, busy, dbg_state);
      end
      n_checks++;
      if (sk_in !== 8'hFF) begin
         n_errors++;
         $display("FAIL sk_in_hold: got %h expected ff", sk_in);
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (sk_in !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err_count !== 9'd0 ||
          fail_valid !== 1'b0 || first_fail !== 8'h00 || dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_values: sk_in=%h busy=%b done=%b err=%0d fv=%b ff=%h state=%0d expected all 0",
                  sk_in, busy, done, err_count, fail_valid, first_fail, dbg_state);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_clean_sweep();
      mode = MODE_GOLD;
      push_exp(DONE_EDGE, 0, 1'b0, 8'h00);
      drive_sweep(1'b0);
   endtask

   task automatic test_tied_low();
      mode = MODE_LOW;
      push_exp(DONE_EDGE, 148, 1'b1, 8'h01);
      drive_sweep(1'b0);
   endtask

   task automatic test_tied_high();
      mode = MODE_HIGH;
      push_exp(DONE_EDGE, 108, 1'b1, 8'h00);
      drive_sweep(1'b0);
   endtask

   // Force the inverse of the known golden value at one vector only.
   task automatic test_spot(input logic [3:0] s, input logic [3:0] t, input logic g);
      mode       = MODE_SPOT;
      spot_vec   = {t, s};
      spot_wrong = ~g;
      push_exp(DONE_EDGE, 1, 1'b1, {t, s});
      drive_sweep(1'b0);
   endtask

   task automatic test_reset_mid_sweep();
      int stray;
      mode = MODE_LOW;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2000) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (sk_in !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err_count !== 9'd0 ||
          fail_valid !== 1'b0 || first_fail !== 8'h00 || dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL mid_reset_values: sk_in=%h busy=%b done=%b err=%0d fv=%b ff=%h state=%0d expected all 0",
                  sk_in, busy, done, err_count, fail_valid, first_fail, dbg_state);
      end
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) stray++;
      end
      n_checks++;
      if (stray !== 0) begin
         n_errors++;
         $display("FAIL mid_reset_idle: %0d cycles with done/busy, expected 0", stray);
      end
      mode = MODE_LOW;
      push_exp(DONE_EDGE, 148, 1'b1, 8'h01);
      drive_sweep(1'b0);
   endtask

   task automatic test_start_ignored();
      mode = MODE_GOLD;
      push_exp(DONE_EDGE, 0, 1'b0, 8'h00);
      drive_sweep(1'b1);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      n_checks   = 0;
      n_errors   = 0;
      mode       = MODE_GOLD;
      spot_vec   = 8'h00;
      spot_wrong = 1'b0;
      rst        = 1'b1;
      start      = 1'b0;

      test_reset();
      test_clean_sweep();
      test_tied_low();
      test_tied_high();
      test_spot(4'h8, 4'hE, 1'b1);
      test_spot(4'h8, 4'hF, 1'b0);
      test_spot(4'h7, 4'h6, 1'b1);
      test_reset_mid_sweep();
      test_start_ignored();

      n_checks++;
      if (exp_q.size() !== 0) begin
         n_errors++;
         $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
